// File: rtl/if_id_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_pkg : shared defaults and constants for the IF/ID register |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package if_id_pkg;

  localparam int          c_ADDR_W    = 32;
  localparam int          c_INSTR_W   = 32;
  localparam int          c_CNT_W     = 16;
  localparam logic [31:0] c_NOP_INSTR = 32'h00000020;  // add $0,$0,$0

  // Saturation value of the stall counter at its default width.
  localparam logic [c_CNT_W-1:0] c_STALL_SAT = '1;

endpackage
`default_nettype wire

// File: rtl/if_id_stage_reg_pipe_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_slot : valid + PC/instruction register, load/clear/hold     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipe_slot #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] instr
);

  logic               r_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;

  // Clear keeps the address so decode still sees the last PC behind a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= NOP_INSTR;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (load) begin
      r_valid <= 1'b1;
      r_addr  <= d_addr;
      r_instr <= d_instr;
    end
  end

  assign valid = r_valid;
  assign addr  = r_addr;
  assign instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/if_id_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_stage_reg : IF/ID register with skid buffer, flush, stats  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module if_id_stage_reg
  import if_id_pkg::*;
#(
  parameter int                 ADDR_W    = c_ADDR_W,
  parameter int                 INSTR_W   = c_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(c_NOP_INSTR),
  parameter int                 CNT_W     = c_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic               Flush,
  output logic [ADDR_W-1:0]  New_Address,
  output logic [INSTR_W-1:0] New_Instr,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [CNT_W-1:0]   StallCount
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic               w_accept;
  logic               w_main_free;
  logic               w_main_load;
  logic               w_main_clear;
  logic               w_main_from_skid;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic [ADDR_W-1:0]  w_main_d_addr;
  logic [INSTR_W-1:0] w_main_d_instr;
  logic               w_skid_valid;
  logic [ADDR_W-1:0]  w_skid_addr;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [CNT_W-1:0]   r_stall_cnt;

  // The skid can only be occupied while main is, so a free skid slot means room.
  assign In_Ready = !w_skid_valid;

  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    w_accept         = In_Valid && !w_skid_valid;
    w_main_free      = !Out_Valid || Out_Ready;

    if (Flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (w_main_free) begin
      if (w_skid_valid) begin
        w_main_load      = 1'b1;
        w_main_from_skid = 1'b1;
        if (w_accept) w_skid_load  = 1'b1;
        else          w_skid_clear = 1'b1;
      end else if (w_accept) begin
        w_main_load = 1'b1;
      end else begin
        w_main_clear = 1'b1;
      end
    end else if (w_accept) begin
      w_skid_load = 1'b1;
    end
  end

  assign w_main_d_addr  = w_main_from_skid ? w_skid_addr  : Address;
  assign w_main_d_instr = w_main_from_skid ? w_skid_instr : Instr;

  pipe_slot #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_main (
    .CLK    (CLK),
    .RST    (RST),
    .load   (w_main_load),
    .clear  (w_main_clear),
    .d_addr (w_main_d_addr),
    .d_instr(w_main_d_instr),
    .valid  (Out_Valid),
    .addr   (New_Address),
    .instr  (New_Instr)
  );

  pipe_slot #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .CLK    (CLK),
    .RST    (RST),
    .load   (w_skid_load),
    .clear  (w_skid_clear),
    .d_addr (Address),
    .d_instr(Instr),
    .valid  (w_skid_valid),
    .addr   (w_skid_addr),
    .instr  (w_skid_instr)
  );

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (Out_Valid && !Out_Ready && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_if_id_stage_reg : vector table, corner sequences, random run  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h00000020;
  localparam logic [31:0] IA  = 32'h8C010004;
  localparam logic [31:0] IB  = 32'h00221820;
  localparam logic [31:0] IC  = 32'hAC030008;

  logic        CLK = 1'b0;
  logic        RST, Flush, In_Valid, Out_Ready;
  logic [31:0] Address, Instr;
  logic        In_Ready, Out_Valid, In_Ready4, Out_Valid4;
  logic [31:0] New_Address, New_Instr, New_Address4, New_Instr4;
  logic [15:0] StallCount;
  logic [3:0]  StallCount4;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  if_id_stage_reg dut (
    .CLK(CLK), .RST(RST), .Address(Address), .Instr(Instr),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Flush(Flush),
    .New_Address(New_Address), .New_Instr(New_Instr),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .StallCount(StallCount)
  );

  if_id_stage_reg #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .Address(Address), .Instr(Instr),
    .In_Valid(In_Valid), .In_Ready(In_Ready4), .Flush(Flush),
    .New_Address(New_Address4), .New_Instr(New_Instr4),
    .Out_Valid(Out_Valid4), .Out_Ready(Out_Ready), .StallCount(StallCount4)
  );

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] addr, instr;
    logic        ordy;
    logic        ev;
    logic [31:0] ea, ei;
    logic        er;
    int          es;
  } vec_t;

  vec_t vq[$];

  typedef struct {
    logic [31:0] addr, instr;
  } word_t;

  word_t       mq[$];
  logic [31:0] m_last;
  int          m_stall;

  task automatic add(input logic r, f, iv, input logic [31:0] a, i, input logic o,
                     input logic ev, input logic [31:0] ea, ei, input logic er, input int es);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.addr = a; v.instr = i; v.ordy = o;
    v.ev = ev; v.ea = ea; v.ei = ei; v.er = er; v.es = es;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, f, iv, input logic [31:0] a, i, input logic o);
    RST = r; Flush = f; In_Valid = iv; Address = a; Instr = i; Out_Ready = o;
  endtask

  // Both instances checked against the same expectation; the 4-bit one saturates at 15.
  task automatic check_all(input string name, input logic ev, input logic [31:0] ea, ei,
                           input logic er, input int es);
    logic [81:0] act, exp, act4, exp4;
    int          es16, es4;
    es16 = (es > 65535) ? 65535 : es;
    es4  = (es > 15) ? 15 : es;
    act  = {Out_Valid, New_Address, New_Instr, In_Ready, StallCount};
    exp  = {ev, ea, ei, er, 16'(es16)};
    act4 = {Out_Valid4, New_Address4, New_Instr4, In_Ready4, 12'd0, StallCount4};
    exp4 = {ev, ea, ei, er, 16'(es4)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got v/addr/instr/rdy/cnt=%h want %h", name, act, exp);
    end
    tests++;
    if (act4 !== exp4) begin
      fails++;
      $display("FAIL %s_cnt4: got v/addr/instr/rdy/cnt=%h want %h", name, act4, exp4);
    end
  endtask

  // Reference: a FIFO of at most two words; head is what decode sees.
  task automatic model_step();
    word_t w;
    logic  acc;
    if (RST) begin
      mq.delete();
      m_last  = '0;
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !Out_Ready) m_stall++;
      if (Flush) begin
        mq.delete();
      end else begin
        acc = In_Valid && (mq.size() < 2);
        if (mq.size() > 0 && Out_Ready) void'(mq.pop_front());
        if (acc) begin
          w.addr = Address; w.instr = Instr;
          mq.push_back(w);
        end
        if (mq.size() > 0) m_last = mq[0].addr;
      end
    end
  endtask

  initial begin
    drive(1, 0, 1, 32'h0, IA, 1);

    //   rst f iv addr   instr ordy   ev ea     ei   er es
    add(1, 0, 1, 32'h0, IA, 1,  0, 32'h0, NOP, 1, 0);
    add(1, 0, 1, 32'h0, IA, 1,  0, 32'h0, NOP, 1, 0);
    add(0, 0, 1, 32'h0, IA, 1,  1, 32'h0, IA,  1, 0);
    add(0, 0, 1, 32'h4, IB, 1,  1, 32'h4, IB,  1, 0);
    add(0, 0, 1, 32'h8, IC, 1,  1, 32'h8, IC,  1, 0);
    add(0, 0, 0, 32'h0, 0,  1,  0, 32'h8, NOP, 1, 0);
    add(0, 0, 1, 32'h0, IA, 1,  1, 32'h0, IA,  1, 0);
    add(0, 0, 1, 32'h4, IB, 0,  1, 32'h0, IA,  0, 1);
    add(0, 0, 1, 32'h8, IC, 0,  1, 32'h0, IA,  0, 2);
    add(0, 0, 0, 32'h0, 0,  1,  1, 32'h4, IB,  1, 2);
    add(0, 0, 0, 32'h0, 0,  1,  0, 32'h4, NOP, 1, 2);
    add(0, 0, 1, 32'h0, IA, 0,  1, 32'h0, IA,  1, 2);
    add(0, 0, 1, 32'h4, IB, 0,  1, 32'h0, IA,  0, 3);
    add(0, 1, 1, 32'h8, IC, 0,  0, 32'h0, NOP, 1, 4);
    add(0, 0, 0, 32'h0, 0,  1,  0, 32'h0, NOP, 1, 4);
    add(0, 0, 1, 32'h0, IA, 0,  1, 32'h0, IA,  1, 4);
    add(0, 0, 1, 32'h4, IB, 0,  1, 32'h0, IA,  0, 5);
    add(1, 0, 0, 32'h0, 0,  0,  0, 32'h0, NOP, 1, 0);
    add(0, 0, 1, 32'h8, IC, 0,  1, 32'h8, IC,  1, 0);
    add(0, 0, 0, 32'h0, 0,  1,  0, 32'h8, NOP, 1, 0);

    @(negedge CLK);
    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].flush, vq[k].iv, vq[k].addr, vq[k].instr, vq[k].ordy);
      @(posedge CLK);
      @(negedge CLK);
      check_all($sformatf("vec%0d", k), vq[k].ev, vq[k].ea, vq[k].ei, vq[k].er, vq[k].es);
    end

    // Long stall: the 4-bit counter must pin at 15 while the wide one keeps counting.
    drive(1, 0, 0, 32'h0, 0, 0);
    @(posedge CLK); @(negedge CLK);
    drive(0, 0, 1, 32'h0, IA, 0);
    @(posedge CLK); @(negedge CLK);
    check_all("sat_load", 1, 32'h0, IA, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 32'h0, 0, 0);
      @(posedge CLK); @(negedge CLK);
      check_all($sformatf("sat%0d", k), 1, 32'h0, IA, 1, k);
    end
    drive(0, 0, 0, 32'h0, 0, 1);
    @(posedge CLK); @(negedge CLK);
    check_all("sat_release", 0, 32'h0, NOP, 1, 20);

    // Randomised traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      drive((n == 0) || ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom, $urandom,
            ($urandom_range(0, 2) != 0));
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_all($sformatf("rnd%0d", n), (mq.size() > 0), m_last,
                (mq.size() > 0) ? mq[0].instr : NOP, (mq.size() < 2), m_stall);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
